watchdog_reset_gen: RTL and testbench

//   Watchdog timer that produces a reset request when software/logic stops "kicking" it.

---
 rtl/watchdog_reset_gen.sv | 125 ++++++++++++
 tb/tb_watchdog_reset_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_reset_gen.sv
// Watchdog timer: raises a PULSE_LEN-cycle reset_req pulse when not kicked within TIMEOUT cycles.
// Ports: clk, rst (sync, active-high), enable, kick in; reset_req, warn, running, fire_count out.
module watchdog_reset_gen #(
    parameter int TIMEOUT     = 1000000,
    parameter int PULSE_LEN   = 16,
    parameter int WARN_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       kick,
    output logic       reset_req,
    output logic       warn,
    output logic       running,
    output logic [7:0] fire_count
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    localparam logic [CW-1:0] CNT_LOAD   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WARN_LIM   = CW'(WARN_CYCLES);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("watchdog_reset_gen: TIMEOUT must be >= 2");
        end
        if (PULSE_LEN < 1) begin : g_bad_pulse
            $error("watchdog_reset_gen: PULSE_LEN must be >= 1");
        end
        if (WARN_CYCLES < 0 || WARN_CYCLES >= TIMEOUT) begin : g_bad_warn
            $error("watchdog_reset_gen: WARN_CYCLES must be in [0, TIMEOUT)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [7:0]      fire_d;
    logic            reset_req_d;
    logic            warn_d;
    logic            running_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_LOAD;
            pcnt_q     <= '0;
            fire_count <= '0;
            reset_req  <= 1'b0;
            warn       <= 1'b0;
            running    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            fire_count <= fire_d;
            reset_req  <= reset_req_d;
            warn       <= warn_d;
            running    <= running_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        fire_d  = fire_count;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COUNT;
                    cnt_d   = CNT_LOAD;
                end
            end
            COUNT: begin
                // disable beats kick, kick beats expiry
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = CNT_LOAD;
                end else if (kick) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = FIRE;
                    pcnt_d  = PULSE_LOAD;
                    if (fire_count != 8'hFF) begin
                        fire_d = fire_count + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIRE: begin
                // pulse always runs to completion; enable only chooses the exit
                if (pcnt_q == '0) begin
                    state_d = enable ? COUNT : IDLE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    pcnt_d = pcnt_q - PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_LOAD;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        reset_req_d = (state_d == FIRE);
        running_d   = (state_d == COUNT);
        warn_d      = (state_d == COUNT) && (cnt_d < WARN_LIM);
    end

endmodule

// File: tb/tb_watchdog_reset_gen.sv
// Directed testbench for watchdog_reset_gen (TIMEOUT=16, PULSE_LEN=4, WARN_CYCLES=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_watchdog_reset_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       kick;
    logic       reset_req;
    logic       warn;
    logic       running;
    logic [7:0] fire_count;

    int checks = 0;
    int errors = 0;

    watchdog_reset_gen #(
        .TIMEOUT    (16),
        .PULSE_LEN  (4),
        .WARN_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .kick      (kick),
        .reset_req (reset_req),
        .warn      (warn),
        .running   (running),
        .fire_count(fire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        kick   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (reset_req !== 1'b0 || warn !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b warn=%b run=%b exp 0 0 0",
                     reset_req, warn, running);
        end
        checks++;
        if (fire_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_fire_count: got %0d exp 0", fire_count);
        end
        // kick in IDLE does nothing
        kick = 1'b1;
        tick();
        kick = 1'b0;
        checks++;
        if (running !== 1'b0 || reset_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_kick: got run=%b req=%b exp 0 0", running, reset_req);
        end
    endtask

    task automatic test_expiry();
        logic exp_req;
        logic exp_run;
        do_reset();
        enable = 1'b1;
        tick();
        checks++;
        if (running !== 1'b1 || reset_req !== 1'b0) begin
            errors++;
            $display("FAIL expiry_E0: got run=%b req=%b exp 1 0", running, reset_req);
        end
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp_req = ((e >= 16 && e <= 19) || (e >= 36 && e <= 39));
            exp_run = !exp_req;
            checks++;
            if (reset_req !== exp_req || running !== exp_run) begin
                errors++;
                $display("FAIL expiry_E%0d: got req=%b run=%b exp %b %b",
                         e, reset_req, running, exp_req, exp_run);
            end
            if (e == 16 || e == 36) begin
                checks++;
                if (fire_count !== ((e == 16) ? 8'd1 : 8'd2)) begin
                    errors++;
                    $display("FAIL expiry_count_E%0d: got %0d", e, fire_count);
                end
            end
        end
    endtask

    task automatic test_kick_period();
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 1; i <= 300; i++) begin
            kick = (i % 16 == 0);
            tick();
            checks++;
            if (reset_req !== 1'b0) begin
                errors++;
                $display("FAIL kick16_cycle%0d: got req=%b exp 0", i, reset_req);
            end
        end
        // one kick, then the 17-cycle gap never arrives in time
        kick = 1'b1;
        tick();
        kick = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            tick();
            checks++;
            if (reset_req !== (j == 16)) begin
                errors++;
                $display("FAIL kick17_edge%0d: got req=%b exp %b",
                         j, reset_req, (j == 16));
            end
        end
    endtask

    task automatic test_warn();
        logic exp_warn;
        do_reset();
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_warn = (e >= 12 && e <= 15);
            checks++;
            if (warn !== exp_warn) begin
                errors++;
                $display("FAIL warn_E%0d: got %b exp %b", e, warn, exp_warn);
            end
        end
        // reloaded at E20; cnt=3 after E32
        for (int e = 21; e <= 32; e++) tick();
        checks++;
        if (warn !== 1'b1) begin
            errors++;
            $display("FAIL warn_before_kick: got %b exp 1", warn);
        end
        kick = 1'b1;
        tick();
        kick = 1'b0;
        checks++;
        if (warn !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL warn_after_kick: got warn=%b run=%b exp 0 1", warn, running);
        end
    endtask

    task automatic test_disable();
        int fires;
        do_reset();
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 10; e++) tick();
        enable = 1'b0;
        tick();
        checks++;
        if (running !== 1'b0 || reset_req !== 1'b0) begin
            errors++;
            $display("FAIL disable_idle: got run=%b req=%b exp 0 0", running, reset_req);
        end
        fires = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (reset_req === 1'b1 || running === 1'b1) fires++;
        end
        checks++;
        if (fires !== 0) begin
            errors++;
            $display("FAIL disable_no_pulse: got %0d active cycles exp 0", fires);
        end
        // re-enable: full 16-cycle timeout
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 16; e++) begin
            tick();
            checks++;
            if (reset_req !== (e == 16)) begin
                errors++;
                $display("FAIL reenable_E%0d: got req=%b exp %b", e, reset_req, (e == 16));
            end
        end
        // kick on the edge where cnt==0
        do_reset();
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 15; e++) tick();
        kick = 1'b1;
        tick();
        kick = 1'b0;
        checks++;
        if (reset_req !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL kick_at_zero: got req=%b run=%b exp 0 1", reset_req, running);
        end
        for (int j = 1; j <= 16; j++) begin
            tick();
            checks++;
            if (reset_req !== (j == 16)) begin
                errors++;
                $display("FAIL after_zero_kick_%0d: got req=%b exp %b",
                         j, reset_req, (j == 16));
            end
        end
    endtask

    task automatic test_fire_rst_and_toggle();
        do_reset();
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 16; e++) tick();
        checks++;
        if (reset_req !== 1'b1 || fire_count !== 8'd1) begin
            errors++;
            $display("FAIL pre_rst_fire: got req=%b cnt=%0d exp 1 1", reset_req, fire_count);
        end
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (reset_req !== 1'b0 || fire_count !== 8'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_fire: got req=%b cnt=%0d run=%b exp 0 0 0",
                     reset_req, fire_count, running);
        end
        tick();
        checks++;
        if (reset_req !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL rst_then_idle: got req=%b run=%b exp 0 0", reset_req, running);
        end
        // toggle enable and kick during FIRE
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 16; e++) tick();
        for (int e = 17; e <= 20; e++) begin
            enable = (e % 2 == 0);
            kick   = (e == 18);
            tick();
            checks++;
            if (reset_req !== (e != 20)) begin
                errors++;
                $display("FAIL toggle_E%0d: got req=%b exp %b", e, reset_req, (e != 20));
            end
        end
        kick = 1'b0;
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL toggle_exit: got run=%b exp 1", running);
        end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        do_reset();
        enable = 1'b1;
        tick();
        for (int e = 1; e <= 6000; e++) begin
            tick();
            if (e % 500 == 0 || e == 5076 || e == 5096 || e == 5116) begin
                exp_cnt = (e + 4) / 20;
                if (exp_cnt > 255) exp_cnt = 255;
                checks++;
                if (fire_count !== 8'(exp_cnt)) begin
                    errors++;
                    $display("FAIL saturate_E%0d: got %0d exp %0d", e, fire_count, exp_cnt);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        kick   = 1'b0;
        test_reset();
        test_expiry();
        test_kick_period();
        test_warn();
        test_disable();
        test_fire_rst_and_toggle();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
